i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 The block SHALL have parameter DIV, default 4, giving the clk cycles per quarter SCL period (legal range 2..255).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port start  input  1  transaction request, sampled only in IDLE.
REQ-005 The block SHALL have port rw  input  1  direction bit: 0 = write, 1 = read.
REQ-006 The block SHALL have port addr  input  7  target address, sent MSB first.
REQ-007 The block SHALL have port wdata  input  8  write byte, sent MSB first.
REQ-008 The block SHALL have port rdata  output  8  read byte, valid while done is high.
REQ-009 The block SHALL have port busy  output  1  high from start acceptance until the STOP completes.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse at the end of a transaction.
REQ-011 The block SHALL have port ack_err  output  1  NACK seen in the last transaction; valid with done.
REQ-012 The block SHALL have port scl  output  1  bus clock, push-pull.
REQ-013 The block SHALL have port sda  inout  1  bus data, open-drain: driven 0 or high-Z only, never driven 1.

Function
REQ-014 A quarter-tick counter SHALL count 0..DIV-1 while busy; each state phase lasts exactly one quarter (DIV clks).
REQ-015 FSM states SHALL be IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP.
REQ-016 In IDLE with start=1, the block SHALL latch addr, rw and wdata, set busy on the next cycle, clear ack_err, and enter START.
REQ-017 Changes to addr, rw and wdata while busy SHALL have no effect.
REQ-018 start=1 while busy SHALL be ignored, not queued.
REQ-019 START SHALL last 2 quarters: Q0 has scl=1 with sda released; Q1 has scl=1 with sda=0.
REQ-020 Each bit slot SHALL last 4 quarters: Q0 scl=0 and sda updated at its first clk; Q1 scl=0; Q2 and Q3 scl=1.
REQ-021 The receiver of a bit slot SHALL sample sda on the last clk of Q2.
REQ-022 ADDR SHALL send 8 bit slots: addr[6:0] then rw.
REQ-023 In ACK_A, the block SHALL release sda for 1 bit slot and sample it; sda=1 (NACK) SHALL set ack_err and go to STOP, skipping DATA.
REQ-024 In write DATA, the block SHALL send the 8 bits of wdata; in ACK_D it SHALL release sda and sample it, setting ack_err on 1, then go to STOP.
REQ-025 In read DATA, the block SHALL release sda and shift in 8 samples MSB first; in ACK_D it SHALL release sda (master NACK), then go to STOP.
REQ-026 STOP SHALL last 3 quarters: Q0 scl=0 with sda=0; Q1 scl=1 with sda=0; Q2 scl=1 with sda released.
REQ-027 At the end of STOP, the block SHALL return to IDLE, clear busy, and pulse done for 1 clk.
REQ-028 In a read, rdata SHALL update on the same clk that done rises and hold until the next read completes.
REQ-029 Transaction length SHALL be 77*DIV clks from start acceptance to done, or 41*DIV clks on an address NACK.
REQ-030 In IDLE, scl SHALL be 1 and sda SHALL be released.
REQ-031 The block SHALL perform no clock stretching and no arbitration; scl is never sampled.

Reset
REQ-032 While rst_n=0 at a clk edge, the block SHALL enter IDLE with scl=1, sda released, busy=0, done=0, ack_err=0, rdata=8'h00, and quarter and bit counters at 0.
REQ-033 Reset asserted mid-transaction SHALL abort at once, with no STOP generated, and no done pulse SHALL follow.
REQ-034 start asserted during the reset cycle SHALL be ignored.

Verification
REQ-035 Write, DIV=4, addr=7'h2A, wdata=8'hC3, ACKing slave model -> bus shows START, 0x54, ACK, 0xC3, ACK, STOP; done at 308 clks; ack_err=0.
REQ-036 Write to addr=7'h11 with no slave (sda pulled up) -> ack_err=1; STOP follows ACK_A; done at 164 clks with DIV=4.
REQ-037 Read, addr=7'h2A, slave returns 8'hA5 -> address byte 0x55, master NACK on the 9th slot, rdata=8'hA5 with done, ack_err=0.
REQ-038 start pulsed again at mid-DATA, with addr and wdata changed -> the in-flight transaction is unaltered and no second transaction runs.
REQ-039 rst_n=0 for 1 clk during ADDR bit 3 -> next cycle scl=1, sda=Z, busy=0; no done pulse.
REQ-040 A bus monitor over all scenarios SHALL check that sda changes only while scl=0, except at START and STOP, and that sda is never driven 1.

Source files
------------

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C master (START, address+rw, one data byte, STOP)
// Every bus phase is one quarter of DIV clks; scl and the sda pull-down are registered.
module i2c_master #(
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       scl,
   inout  wire        sda
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      ADDR,
      ACK_A,
      DATA,
      ACK_D,
      STOP
   } state_t;

   state_t     state;
   logic [7:0] qcnt;
   logic [1:0] quarter;
   logic [2:0] bitcnt;
   logic [7:0] addr_byte;
   logic [7:0] wdata_r;
   logic [7:0] shift;
   logic       sda_low;
   logic       sda_in;
   logic       q_end;
   logic       last_q;
   logic       tx_bit;

   assign sda    = sda_low ? 1'b0 : 1'bz;
   assign sda_in = sda;
   assign q_end  = (qcnt == 8'(DIV - 1));

   always_comb begin
      last_q = 1'b0;
      case (state)
         START:   last_q = (quarter == 2'd1);
         STOP:    last_q = (quarter == 2'd2);
         default: last_q = (quarter == 2'd3);
      endcase
   end

   // Level the master wants on sda for the current bit slot; 1 means released.
   always_comb begin
      tx_bit = 1'b1;
      case (state)
         ADDR:    tx_bit = addr_byte[3'd7 - bitcnt];
         DATA:    tx_bit = addr_byte[0] | wdata_r[3'd7 - bitcnt];
         default: tx_bit = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         qcnt      <= 8'd0;
         quarter   <= 2'd0;
         bitcnt    <= 3'd0;
         addr_byte <= 8'h00;
         wdata_r   <= 8'h00;
         shift     <= 8'h00;
         rdata     <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
         ack_err   <= 1'b0;
         scl       <= 1'b1;
         sda_low   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            scl     <= 1'b1;
            sda_low <= 1'b0;
            if (start) begin
               addr_byte <= {addr, rw};
               wdata_r   <= wdata;
               busy      <= 1'b1;
               ack_err   <= 1'b0;
               state     <= START;
               qcnt      <= 8'd0;
               quarter   <= 2'd0;
               bitcnt    <= 3'd0;
            end
         end else if (!q_end) begin
            qcnt <= qcnt + 8'd1;
            // sda moves one clk after scl falls so it never races the falling edge
            if (qcnt == 8'd0 && quarter == 2'd0) begin
               if (state == STOP) begin
                  sda_low <= 1'b1;
               end else if (state != START) begin
                  sda_low <= ~tx_bit;
               end
            end
         end else if (!last_q) begin
            qcnt    <= 8'd0;
            quarter <= quarter + 2'd1;
            case (state)
               START: sda_low <= 1'b1;
               STOP: begin
                  if (quarter == 2'd0) begin
                     scl <= 1'b1;
                  end else begin
                     sda_low <= 1'b0;
                  end
               end
               default: begin
                  if (quarter == 2'd1) begin
                     scl <= 1'b1;
                  end
                  // End of Q2 is the sampling point of every bit slot
                  if (quarter == 2'd2) begin
                     if (state == ACK_A && sda_in) begin
                        ack_err <= 1'b1;
                     end
                     if (state == ACK_D && !addr_byte[0] && sda_in) begin
                        ack_err <= 1'b1;
                     end
                     if (state == DATA && addr_byte[0]) begin
                        shift <= {shift[6:0], sda_in};
                     end
                  end
               end
            endcase
         end else begin
            qcnt    <= 8'd0;
            quarter <= 2'd0;
            case (state)
               START: begin
                  scl    <= 1'b0;
                  bitcnt <= 3'd0;
                  state  <= ADDR;
               end
               ADDR: begin
                  scl    <= 1'b0;
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) begin
                     state <= ACK_A;
                  end
               end
               ACK_A: begin
                  scl    <= 1'b0;
                  bitcnt <= 3'd0;
                  state  <= ack_err ? STOP : DATA;
               end
               DATA: begin
                  scl    <= 1'b0;
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) begin
                     state <= ACK_D;
                  end
               end
               ACK_D: begin
                  scl   <= 1'b0;
                  state <= STOP;
               end
               STOP: begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  sda_low <= 1'b0;
                  if (addr_byte[0]) begin
                     rdata <= shift;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - scoreboard bench for i2c_master with a slave model and bus monitor
module tb_i2c_master;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = 7'h00;
   logic [7:0] wdata = 8'h00;
   wire  [7:0] rdata;
   wire        busy;
   wire        done;
   wire        ack_err;
   wire        scl;
   wire        sda;
   logic       slave_low = 1'b0;

   pullup (sda);
   assign sda = slave_low ? 1'b0 : 1'bz;

   i2c_master #(.DIV(DIV)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .rw(rw),
      .addr(addr),
      .wdata(wdata),
      .rdata(rdata),
      .busy(busy),
      .done(done),
      .ack_err(ack_err),
      .scl(scl),
      .sda(sda)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rdata;
      logic       ack;
      int         acc;
      int         lat;
   } txn_t;

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic       ack8;
      logic       ack17;
      int         nslots;
   } bus_t;

   txn_t sq[$];
   bus_t bq[$];

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int done_seen = 0;
   int pushed = 0;
   logic done_prev = 1'b0;
   logic [7:0] last_rd = 8'h00;

   logic       slave_present = 1'b0;
   logic [7:0] slave_byte = 8'h00;
   logic       bus_ignore = 1'b0;
   logic       bus_active = 1'b0;
   int         slot = 0;
   logic       bits [0:31];
   logic       p_scl = 1'b1;
   logic       p_sda = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Done monitor: pops the transaction scoreboard
   always @(negedge clk) begin
      if (done) begin
         txn_t e;
         done_seen++;
         check("done_width", 32'(done_prev), 32'd0);
         if (sq.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sq.pop_front();
            check("ack_err", 32'(ack_err), 32'(e.ack));
            check("rdata", 32'(rdata), 32'(e.rdata));
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
      done_prev <= done;
   end

   // Bus monitor: slot capture on scl rise, START/STOP on sda edges while scl is high
   always @(scl or sda) begin
      if (bus_ignore) begin
         bus_active = 1'b0;
      end else if (scl !== p_scl) begin
         if (scl === 1'b1 && bus_active && slot < 32) begin
            bits[slot] = sda;
            slot++;
         end
      end else if (sda !== p_sda && scl === 1'b1) begin
         if (sda === 1'b0) begin
            check("start_while_active", 32'(bus_active), 32'd0);
            bus_active = 1'b1;
            slot = 0;
         end else begin
            bus_t e;
            logic [7:0] b0;
            logic [7:0] b1;
            check("stop_while_idle", 32'(bus_active), 32'd1);
            if (bq.size() == 0) begin
               check("stray_stop", 32'd1, 32'd0);
            end else begin
               e = bq.pop_front();
               for (int i = 0; i < 8; i++) begin
                  b0[7-i] = bits[i];
                  b1[7-i] = bits[9+i];
               end
               check("bus_slots", 32'(slot), 32'(e.nslots));
               check("bus_addr_byte", 32'(b0), 32'(e.b0));
               check("bus_ack_addr", 32'(bits[8]), 32'(e.ack8));
               if (e.nslots == 19) begin
                  check("bus_data_byte", 32'(b1), 32'(e.b1));
                  check("bus_ack_data", 32'(bits[17]), 32'(e.ack17));
               end
            end
            bus_active = 1'b0;
         end
      end
      p_scl = scl;
      p_sda = sda;
   end

   // Slave model: drives only while scl is low, shortly after it falls
   always @(negedge scl) begin
      #1;
      if (!bus_active || !slave_present) begin
         slave_low = 1'b0;
      end else if (slot == 8) begin
         slave_low = 1'b1;
      end else if (bits[7] && slot >= 9 && slot <= 16) begin
         slave_low = ~slave_byte[16-slot];
      end else if (!bits[7] && slot == 17) begin
         slave_low = 1'b1;
      end else begin
         slave_low = 1'b0;
      end
   end

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] d,
                          input logic present, input logic [7:0] sbyte, input logic repulse);
      txn_t t;
      bus_t b;
      @(negedge clk);
      slave_present = present;
      slave_byte = sbyte;
      rw = r;
      addr = a;
      wdata = d;
      start = 1'b1;
      t.acc = cyc + 1;
      t.ack = ~present;
      t.lat = present ? 77 * DIV : 41 * DIV;
      if (r && present) last_rd = sbyte;
      t.rdata = last_rd;
      b.b0 = {a, r};
      b.b1 = r ? sbyte : d;
      b.ack8 = ~present;
      b.ack17 = r;
      b.nslots = present ? 19 : 10;
      sq.push_back(t);
      bq.push_back(b);
      pushed++;
      @(negedge clk);
      start = 1'b0;
      if (repulse) begin
         repeat (215) @(negedge clk);
         start = 1'b1;
         addr = 7'h7F;
         wdata = 8'hFF;
         rw = ~r;
         @(negedge clk);
         start = 1'b0;
      end
      wait_idle("txn_timeout");
      repeat (20) @(negedge clk);
      check("idle_after_txn", 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      start = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check("rst_scl", 32'(scl), 32'd1);
      check("rst_sda", 32'(sda), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ack_err", 32'(ack_err), 32'd0);
      check("rst_rdata", 32'(rdata), 32'h00);

      run_txn(1'b0, 7'h2A, 8'hC3, 1'b1, 8'h00, 1'b0);
      run_txn(1'b0, 7'h11, 8'h5A, 1'b0, 8'h00, 1'b0);
      run_txn(1'b1, 7'h2A, 8'h00, 1'b1, 8'hA5, 1'b0);
      run_txn(1'b0, 7'h3C, 8'h5A, 1'b1, 8'h00, 1'b1);

      // Abort in the middle of ADDR bit 3
      @(negedge clk);
      slave_present = 1'b1;
      rw = 1'b0;
      addr = 7'h2A;
      wdata = 8'hC3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (58) @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'd1);
      bus_ignore = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_scl", 32'(scl), 32'd1);
      check("abort_sda", 32'(sda), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rdata", 32'(rdata), 32'h00);
      last_rd = 8'h00;
      repeat (5) @(negedge clk);
      bus_ignore = 1'b0;
      repeat (400) @(negedge clk);
      check("abort_still_idle", 32'(busy), 32'd0);

      run_txn(1'b1, 7'h4B, 8'h00, 1'b1, 8'h3C, 1'b0);
      run_txn(1'b0, 7'h7F, 8'h00, 1'b1, 8'h00, 1'b0);

      repeat (50) @(negedge clk);
      check("done_count", 32'(done_seen), 32'(pushed));
      check("bus_queue_drained", 32'(bq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
